// File: rtl/filt_cic_interp.sv
// CIC interpolator: low-rate comb section, zero-stuffing upsampler and full-rate integrator section.
// Optional feature FILT_CIC_INTERP_OUP_REG_EN adds an output register (latency N+1, o_vld delayed by 2).
module filt_cic_interp #(
   parameter int gp_interpolation_factor = 4,
   parameter int gp_order                = 2,
   parameter int gp_diff_delay           = 1,
   parameter int gp_inp_width            = 8,
   parameter int gp_oup_width            = gp_inp_width
                                           + gp_order * $clog2(gp_interpolation_factor * gp_diff_delay)
                                           - $clog2(gp_interpolation_factor)
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_ena,
   input  logic signed [gp_inp_width-1:0] i_data,
   output logic                           o_in_req,
   output logic signed [gp_oup_width-1:0] o_data,
   output logic                           o_vld
);

   localparam int lp_w    = gp_inp_width + gp_order * $clog2(gp_interpolation_factor * gp_diff_delay);
   localparam int lp_ph_w = (gp_interpolation_factor > 1) ? $clog2(gp_interpolation_factor) : 1;

   localparam logic [lp_ph_w-1:0]    lp_ph_zero = {lp_ph_w{1'b0}};
   localparam logic [lp_ph_w-1:0]    lp_ph_one  = lp_ph_w'(1);
   localparam logic [lp_ph_w-1:0]    lp_ph_max  = lp_ph_w'(gp_interpolation_factor - 1);
   localparam logic signed [lp_w-1:0] lp_w_zero = {lp_w{1'b0}};

   logic [lp_ph_w-1:0]     phase_r;
   logic                   capture_s;
   logic signed [lp_w-1:0] comb_s  [0:gp_order];
   logic signed [lp_w-1:0] hist_r  [1:gp_order][0:gp_diff_delay-1];
   logic signed [lp_w-1:0] u_r;
   logic signed [lp_w-1:0] integ_r [1:gp_order];
   logic                   vld_r;

   assign capture_s = i_ena && (phase_r == lp_ph_zero);
   assign o_in_req  = capture_s;

   // Phase counter: counts enabled edges modulo R, frozen while i_ena is low
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         phase_r <= lp_ph_zero;
      end else if (i_ena) begin
         if (phase_r == lp_ph_max) begin
            phase_r <= lp_ph_zero;
         end else begin
            phase_r <= phase_r + lp_ph_one;
         end
      end
   end

   // Comb chain: each stage subtracts its input delayed by M captures
   always_comb begin
      comb_s[0] = lp_w'(i_data);
      for (int k = 1; k <= gp_order; k++) begin
         comb_s[k] = comb_s[k-1] - hist_r[k][gp_diff_delay-1];
      end
   end

   // Comb histories, shifted on capture edges only
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 1; k <= gp_order; k++) begin
            for (int j = 0; j < gp_diff_delay; j++) begin
               hist_r[k][j] <= lp_w_zero;
            end
         end
      end else if (capture_s) begin
         for (int k = 1; k <= gp_order; k++) begin
            hist_r[k][0] <= comb_s[k-1];
            for (int j = 1; j < gp_diff_delay; j++) begin
               hist_r[k][j] <= hist_r[k][j-1];
            end
         end
      end
   end

   // Zero-stuffing upsampler
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         u_r <= lp_w_zero;
      end else if (i_ena) begin
         u_r <= capture_s ? comb_s[gp_order] : lp_w_zero;
      end
   end

   // Integrator chain; wrap-around is intentional, the final result is exact modulo 2^W
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 1; k <= gp_order; k++) begin
            integ_r[k] <= lp_w_zero;
         end
      end else if (i_ena) begin
         integ_r[1] <= integ_r[1] + u_r;
         for (int k = 2; k <= gp_order; k++) begin
            integ_r[k] <= integ_r[k] + integ_r[k-1];
         end
      end
   end

`ifdef FILT_CIC_INTERP_OUP_REG_EN
   logic signed [gp_oup_width-1:0] oup_r;
   logic                           vld_d_r;

   // Output register with a two-stage valid pipeline kept aligned to it
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         oup_r   <= {gp_oup_width{1'b0}};
         vld_r   <= 1'b0;
         vld_d_r <= 1'b0;
      end else begin
         vld_r   <= i_ena;
         vld_d_r <= vld_r;
         if (i_ena) begin
            oup_r <= integ_r[gp_order][gp_oup_width-1:0];
         end
      end
   end

   assign o_data = oup_r;
   assign o_vld  = vld_d_r;
`else
   // Valid flag: registered copy of the enable
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_r <= 1'b0;
      end else begin
         vld_r <= i_ena;
      end
   end

   assign o_data = integ_r[gp_order][gp_oup_width-1:0];
   assign o_vld  = vld_r;
`endif

endmodule

// File: tb/tb_filt_cic_interp.sv
// Bench for filt_cic_interp: directed vectors on three configurations, reference from the
// cascaded-boxcar impulse response convolved with the zero-stuffed input.
module tb_filt_cic_interp;

   localparam int IW   = 8;
   localparam int OW_A = IW + 2 * $clog2(4)  - $clog2(4);
   localparam int OW_B = IW + 1 * $clog2(4)  - $clog2(4);
   localparam int OW_C = IW + 3 * $clog2(16) - $clog2(8);
`ifdef FILT_CIC_INTERP_OUP_REG_EN
   localparam int LX = 1;
`else
   localparam int LX = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena_a = 1'b0, ena_b = 1'b0, ena_c = 1'b0;
   logic signed [IW-1:0] dat_a = 8'sd0, dat_b = 8'sd0, dat_c = 8'sd0;
   logic req_a, req_b, req_c, vld_a, vld_b, vld_c;
   logic signed [OW_A-1:0] out_a;
   logic signed [OW_B-1:0] out_b;
   logic signed [OW_C-1:0] out_c;

   int     checks = 0;
   int     errors = 0;
   int     xs   [0:127];
   int     hh   [0:63];
   int     hlen;
   longint obs  [0:255];

   always #5 clk = ~clk;

   filt_cic_interp #(.gp_interpolation_factor(4), .gp_order(2), .gp_diff_delay(1), .gp_inp_width(IW))
      u_a (.i_clk(clk), .i_rst(rst), .i_ena(ena_a), .i_data(dat_a), .o_in_req(req_a), .o_data(out_a), .o_vld(vld_a));
   filt_cic_interp #(.gp_interpolation_factor(4), .gp_order(1), .gp_diff_delay(1), .gp_inp_width(IW))
      u_b (.i_clk(clk), .i_rst(rst), .i_ena(ena_b), .i_data(dat_b), .o_in_req(req_b), .o_data(out_b), .o_vld(vld_b));
   filt_cic_interp #(.gp_interpolation_factor(8), .gp_order(3), .gp_diff_delay(2), .gp_inp_width(IW))
      u_c (.i_clk(clk), .i_rst(rst), .i_ena(ena_c), .i_data(dat_c), .o_in_req(req_c), .o_data(out_c), .o_vld(vld_c));

   task automatic check_val(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Impulse response of N cascaded boxcars of length R*M
   task automatic build_h(input int r, input int m, input int n);
      int tmp [0:63];
      int nl;
      for (int i = 0; i < 64; i++) hh[i] = 0;
      hh[0] = 1;
      hlen  = 1;
      for (int s = 0; s < n; s++) begin
         nl = hlen + r * m - 1;
         for (int i = 0; i < nl; i++) begin
            tmp[i] = 0;
            for (int j = 0; j < r * m; j++)
               if (i - j >= 0 && i - j < hlen) tmp[i] += hh[i-j];
         end
         for (int i = 0; i < nl; i++) hh[i] = tmp[i];
         hlen = nl;
      end
   endtask

   function automatic longint exp_y(input int k, input int r);
      longint acc = 0;
      if (k < 0) return 0;
      for (int j = 0; j < hlen && j <= k; j++)
         if ((k - j) % r == 0) acc += longint'(hh[j]) * longint'(xs[(k-j)/r]);
      return acc;
   endfunction

   task automatic drive(input int inst, input logic e, input int d);
      case (inst)
         0: begin ena_a = e; dat_a = 8'(d); end
         1: begin ena_b = e; dat_b = 8'(d); end
         default: begin ena_c = e; dat_c = 8'(d); end
      endcase
   endtask

   function automatic longint get_data(input int inst);
      case (inst)
         0: return out_a;
         1: return out_b;
         default: return out_c;
      endcase
   endfunction

   function automatic logic get_req(input int inst);
      case (inst)
         0: return req_a;
         1: return req_b;
         default: return req_c;
      endcase
   endfunction

   function automatic logic get_vld(input int inst);
      case (inst)
         0: return vld_a;
         1: return vld_b;
         default: return vld_c;
      endcase
   endfunction

   // Runs n_en enabled cycles from a freshly reset DUT, with an optional enable gap before enabled cycle gap_at
   task automatic run(input int inst, input int n_en, input int gap_at, input int gap_len, input string tag);
      int r, m, n, lat;
      logic h1, h2;
      longint last;
      r    = (inst == 2) ? 8 : 4;
      m    = (inst == 2) ? 2 : 1;
      n    = (inst == 0) ? 2 : ((inst == 1) ? 1 : 3);
      lat  = n + LX;
      h1   = 1'b0;
      h2   = 1'b0;
      last = 0;
      build_h(r, m, n);
      for (int k = 0; k < n_en; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(inst, 1'b0, xs[k/r]);
               #1;
               check_val($sformatf("%s req gap k%0d", tag, k), longint'(get_req(inst)), 0);
               @(posedge clk);
               @(negedge clk);
               h2 = h1;
               h1 = 1'b0;
               check_val($sformatf("%s hold gap k%0d", tag, k), get_data(inst), last);
               check_val($sformatf("%s vld gap k%0d", tag, k), longint'(get_vld(inst)), longint'(LX ? h2 : h1));
            end
         end
         drive(inst, 1'b1, xs[k/r]);
         #1;
         check_val($sformatf("%s req k%0d", tag, k), longint'(get_req(inst)), longint'((k % r) == 0));
         @(posedge clk);
         @(negedge clk);
         h2     = h1;
         h1     = 1'b1;
         last   = exp_y(k - lat, r);
         obs[k] = get_data(inst);
         check_val($sformatf("%s data k%0d", tag, k), obs[k], last);
         check_val($sformatf("%s vld k%0d", tag, k), longint'(get_vld(inst)), longint'(LX ? h2 : h1));
      end
      drive(inst, 1'b0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // idle: enable low, nothing requested, outputs stay at zero
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("idle req", longint'(req_a), 0);
         check_val("idle data", longint'(out_a), 0);
         check_val("idle vld", longint'(vld_a), 0);
      end

      // step of ones, N=2 R=4: 0,0,1,2,3,4,4,...
      for (int i = 0; i < 128; i++) xs[i] = 1;
      run(0, 13 + LX, -1, 0, "step");
      for (int k = 0; k < 12; k++)
         check_val($sformatf("step hand k%0d", k), obs[k+LX], (k < 2) ? 0 : ((k < 6) ? k - 1 : 4));

      // asynchronous reset between edges while mid-period
      drive(0, 1'b1, 1);
      @(posedge clk);
      #1;
      check_val("pre-reset req", longint'(req_a), 0);
      #1;
      rst = 1'b1;
      #1;
      check_val("async rst data", longint'(out_a), 0);
      check_val("async rst vld", longint'(vld_a), 0);
      check_val("async rst phase", longint'(req_a), 1);
      @(negedge clk);
      drive(0, 1'b0, 0);
      rst = 1'b0;

      // full scale negative and positive
      for (int i = 0; i < 128; i++) xs[i] = -128;
      run(0, 12, -1, 0, "fsneg");
      check_val("fsneg settle", obs[11], -512);
      do_reset();
      for (int i = 0; i < 128; i++) xs[i] = 127;
      run(0, 12, -1, 0, "fspos");
      check_val("fspos settle", obs[11], 508);

      // enable gap of 3 cycles at phase 2
      do_reset();
      for (int i = 0; i < 128; i++) xs[i] = 0;
      xs[0] = 5; xs[1] = -3; xs[2] = 7; xs[3] = -128; xs[4] = 127; xs[5] = 2;
      run(0, 24, 6, 3, "gap");

      // impulse, N=1 R=4: four ones after E1
      do_reset();
      for (int i = 0; i < 128; i++) xs[i] = 0;
      xs[0] = 1;
      run(1, 10 + LX, -1, 0, "imp");
      for (int k = 0; k < 10; k++)
         check_val($sformatf("imp hand k%0d", k), obs[k+LX], (k >= 1 && k <= 4) ? 1 : 0);

      // N=3 R=8 M=2 with random samples including both extremes
      do_reset();
      for (int i = 0; i < 128; i++) xs[i] = int'($urandom_range(255)) - 128;
      xs[0] = -128; xs[1] = -128; xs[2] = -128; xs[3] = 127; xs[4] = 127; xs[5] = 127;
      run(2, 200, 37, 2, "rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/filt_cic_interp.md
# filt_cic_interp

CIC interpolation filter: the transmit-side counterpart of `filt_cic`, the decimator. It accepts one low-rate sample every `gp_interpolation_factor` enabled clocks and produces one full-rate output per enabled clock. It sits between a low-rate sample source and a high-rate consumer, such as a DAC or sigma-delta modulator front-end. Internally it is an `gp_order`-stage comb section at the low rate, a zero-stuffing upsampler and an `gp_order`-stage integrator section at the high rate.

## Interface
- `gp_interpolation_factor`, default 4: R, rate change; power of two, ≥1.
- `gp_order`, default 2: N, number of comb stages and of integrator stages; 1..6.
- `gp_diff_delay`, default 1: M, comb differential delay; 1 or 2.
- `gp_inp_width`, default 8: input width, two's complement.
- `gp_oup_width`, default `gp_inp_width + gp_order*clog2(R*M) - clog2(R)`: output width; full precision, no truncation.
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_ena`  in  1  clock enable; when low, all state is frozen.
- `i_data`  in  `gp_inp_width`  signed low-rate sample; sampled on edges where `o_in_req`=1.
- `o_in_req`  out  1  combinational: `i_ena && phase==0`. Upstream must present the next sample while this is high.
- `o_data`  out  `gp_oup_width`  signed full-rate output.
- `o_vld`  out  1  registered copy of `i_ena`; marks edges on which `o_data` advanced.

## Operation
- Internal width W = `gp_inp_width + gp_order*clog2(R*M)`. All comb and integrator registers are W wide, sign-extended from `i_data`, and use modulo-2^W arithmetic. Wrap-around is intentional and must not saturate.
- Phase counter, range 0..R-1: increments on every enabled edge and wraps R-1→0. For R=1 it is constant 0.
- Comb section, updated only on capture edges (`o_in_req`=1):
  - c0 = sext(`i_data`); ck = c(k-1) − c(k-1) delayed M captures; k=1..N.
  - Each stage keeps an M-deep history of its input, shifted on capture edges only.
- Upsampler register `u_r`, updated every enabled edge: cN on a capture edge, 0 otherwise (zero-stuffing).
- Integrator section, every enabled edge:
  - I1 ← I1 + `u_r`; Ik ← Ik + I(k-1), using the old value of I(k-1).
- `o_data` = low `gp_oup_width` bits of IN. These are exact, because the DC gain is (R·M)^N / R.
- Reset (`i_rst`=1, asynchronous): phase, comb histories, `u_r`, all integrators, `o_data` and `o_vld` go to 0. `o_in_req` is 0 while `i_ena`=0.
- Reset during operation discards all history. The first capture after release occurs on the first enabled edge.
- `i_ena` low mid-period: the phase holds, so the next enabled edge resumes the same phase and no sample is dropped or duplicated.

## Timing
- Capture edge E0 (`i_data` sampled) → `u_r` valid after E0 → I1 after E1 → `o_data` reflects the sample after the N-th enabled edge following E0.
- Latency is N enabled cycles, or N+1 with the output register (see Configuration).
- `o_in_req` is asserted exactly once every R enabled cycles. No back-pressure: the source must supply data on every request.
- `o_vld` is 0 out of reset and follows `i_ena` with one cycle of delay.

## Configuration
- `FILT_CIC_INTERP_OUP_REG_EN` defined:
  - `o_data` is an additional register loaded from IN on enabled edges; reset value 0.
  - Latency is N+1 enabled cycles.
  - `o_vld` is delayed by 2 cycles, staying aligned with `o_data`.
- Not defined: `o_data` is driven directly from the IN register; latency N.

## Test plan
- Reset/idle:
  - Assert `i_rst` asynchronously between edges → `o_data`=0, `o_vld`=0, phase=0 immediately.
  - Hold `i_ena`=0 → `o_in_req`=0 and outputs stay 0.
- Step, N=2, R=4, M=1, input constant 1 from the first capture → `o_data` after enabled edges E2..E5 = 1, 2, 3, 4, then 4 forever (gain 4).
- Impulse, N=1, R=4, M=1: input 1 on one capture, then 0 → `o_data` = 1 for exactly 4 consecutive enabled cycles starting after E1, then 0.
- Full scale, defaults: input −128 held → `o_data` settles at −512 with no overflow. Repeat with +127 → +508.
- Enable gaps: deassert `i_ena` for 3 cycles mid-period with N=2, R=4 → the output sequence is identical to the gap-free run with the gaps removed. `o_in_req` spacing is 4 enabled cycles.
- Bit-exact check: random stimuli from the MATLAB model, N=3, R=8, M=2 → zero mismatches against the response file. Run both with and without `FILT_CIC_INTERP_OUP_REG_EN`, with the bench compensating the extra cycle when it is defined.
